// File: rtl/aer_tx_bridge.sv
// AER output bridge: 4-phase REQ/ACK capture into a timestamped event FIFO, then
// serialisation of each event as a 1- or 3-byte frame on an AXI-Stream byte master.
module aer_tx_bridge #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TS_W        = 16,
    parameter int unsigned TS_PRESCALE = 100
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ADDR_W-1:0]             AEROUT_ADDR,
    input  logic                          AEROUT_REQ,
    output logic                          AEROUT_ACK,
    input  logic                          cfg_ts_en,
    input  logic                          ts_clear,
    output logic [ADDR_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned PS_W  = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
    localparam int unsigned ENT_W = ADDR_W + TS_W;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TS_PRESCALE - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        AER_IDLE,
        AER_ACKH
    } aer_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ADDR,
        TX_TSH,
        TX_TSL
    } tx_state_e;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [TS_W-1:0]   ts_q, ts_d;

    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full, empty;
    logic              push, pop;
    logic [ENT_W-1:0]  head;

    aer_state_e        aer_state_q, aer_state_d;
    logic              ack_q, ack_d;

    tx_state_e         tx_state_q, tx_state_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [ADDR_W-1:0] tdata_q, tdata_d;
    logic [TS_W-1:0]   frame_ts_q, frame_ts_d;
    logic              ts_en_q, ts_en_d;
    logic              load;
    logic              beat_done;

    // Timestamp: prescaler wraps every TS_PRESCALE cycles and bumps ts; clear wins.
    always_comb begin
        presc_d = presc_q;
        ts_d    = ts_q;
        if (ts_clear) begin
            presc_d = '0;
            ts_d    = '0;
        end else if (presc_q == PS_LAST) begin
            presc_d = '0;
            ts_d    = ts_q + TS_W'(1);
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    assign full  = (level_q == LVL_FULL);
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // AER handshake: push at most once per REQ, ACK registered one cycle after the push.
    always_comb begin
        aer_state_d = aer_state_q;
        ack_d       = ack_q;
        push        = 1'b0;
        case (aer_state_q)
            AER_IDLE: begin
                if (AEROUT_REQ && !full) begin
                    push        = 1'b1;
                    ack_d       = 1'b1;
                    aer_state_d = AER_ACKH;
                end
            end
            AER_ACKH: begin
                if (!AEROUT_REQ) begin
                    ack_d       = 1'b0;
                    aer_state_d = AER_IDLE;
                end
            end
            default: begin
                ack_d       = 1'b0;
                aer_state_d = AER_IDLE;
            end
        endcase
    end

    assign beat_done = tvalid_q && m_axis_tready;

    // TX framer: load pulls the next event straight into the output register (no bubble).
    always_comb begin
        tx_state_d = tx_state_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        frame_ts_d = frame_ts_q;
        ts_en_d    = ts_en_q;
        pop        = 1'b0;
        load       = 1'b0;
        case (tx_state_q)
            TX_IDLE: load = 1'b1;
            TX_ADDR: begin
                if (beat_done) begin
                    if (ts_en_q) begin
                        tdata_d    = frame_ts_q[TS_W-1 -: ADDR_W];
                        tlast_d    = 1'b0;
                        tx_state_d = TX_TSH;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            TX_TSH: begin
                if (beat_done) begin
                    tdata_d    = frame_ts_q[ADDR_W-1:0];
                    tlast_d    = 1'b1;
                    tx_state_d = TX_TSL;
                end
            end
            TX_TSL: begin
                if (beat_done) begin
                    load = 1'b1;
                end
            end
            default: load = 1'b1;
        endcase
        if (load) begin
            if (!empty) begin
                pop        = 1'b1;
                frame_ts_d = head[TS_W-1:0];
                ts_en_d    = cfg_ts_en;
                tvalid_d   = 1'b1;
                tdata_d    = head[ENT_W-1 -: ADDR_W];
                tlast_d    = ~cfg_ts_en;
                tx_state_d = TX_ADDR;
            end else begin
                tvalid_d   = 1'b0;
                tlast_d    = 1'b0;
                tdata_d    = '0;
                tx_state_d = TX_IDLE;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves the level unchanged.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {AEROUT_ADDR, ts_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            ts_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            aer_state_q <= AER_IDLE;
            ack_q       <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            frame_ts_q  <= '0;
            ts_en_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            ts_q        <= ts_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            aer_state_q <= aer_state_d;
            ack_q       <= ack_d;
            tx_state_q  <= tx_state_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            frame_ts_q  <= frame_ts_d;
            ts_en_q     <= ts_en_d;
        end
    end

    assign AEROUT_ACK    = ack_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign fifo_level    = level_q;

endmodule
